eq_mac_scheduler: RTL and testbench



---
 rtl/eq_pkg.sv | 42 ++++
 rtl/eq_dl_addr_gen.sv | 49 ++++
 rtl/eq_mac_scheduler.sv | 173 +++++++++++++++++
 tb/tb_eq_mac_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared constants, state encoding and band-selection helper for the equalizer
// MAC scheduler.
//   NUM_BANDS / NUM_TAPS : bands processed per sample, taps per band (power of two)
//   TAP_W / BAND_W       : index widths
//   COEF_AW              : coefficient ROM address width {band, tap}
// Optional feature macro used by the importing files: EQ_BAND_BYPASS_EN.
package eq_pkg;

  localparam int unsigned NUM_BANDS = 8;
  localparam int unsigned NUM_TAPS  = 64;
  localparam int unsigned TAP_W     = $clog2(NUM_TAPS);
  localparam int unsigned BAND_W    = $clog2(NUM_BANDS);
  localparam int unsigned COEF_AW   = BAND_W + TAP_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRun   = 2'd2,
    StDump  = 2'd3
  } eq_state_e;

  typedef struct packed {
    logic              found;
    logic [BAND_W-1:0] idx;
  } band_pick_t;

  // Lowest enabled band index >= from; found=0 when none remain.
  // from is one bit wider than a band index so "past the last band" is expressible.
  function automatic band_pick_t next_band(input logic [NUM_BANDS-1:0] mask,
                                           input logic [BAND_W:0]      from);
    band_pick_t pick;
    pick = '0;
    for (int i = int'(NUM_BANDS) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        pick.found = 1'b1;
        pick.idx   = BAND_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/eq_dl_addr_gen.sv
// Circular delay-line address generator.
// Holds the write pointer (wp) and the base of the sample currently being
// processed; produces the write address and the tap read address base - tap.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   en_i          : global advance qualifier
//   wr_stb_i      : sample is being written this cycle (latch base, advance wp)
//   tap_i         : current tap index
//   wr_addr_o     : delay-line write address (wp)
//   rd_addr_o     : delay-line read address, (base - tap) mod NUM_TAPS
module eq_dl_addr_gen
  import eq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             wr_stb_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic [TAP_W-1:0] wr_addr_o,
  output logic [TAP_W-1:0] rd_addr_o
);

  logic [TAP_W-1:0] wp_q, wp_d;
  logic [TAP_W-1:0] base_q, base_d;

  always_comb begin
    wp_d   = wp_q;
    base_d = base_q;
    if (en_i && wr_stb_i) begin
      base_d = wp_q;
      wp_d   = wp_q + 1'b1;  // TAP_W-bit wrap gives 63 -> 0
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q   <= '0;
      base_q <= '0;
    end else begin
      wp_q   <= wp_d;
      base_q <= base_d;
    end
  end

  assign wr_addr_o = wp_q;
  // Tap 0 is the newest sample; older taps walk backwards around the ring.
  assign rd_addr_o = base_q - tap_i;

endmodule

// File: rtl/eq_mac_scheduler.sv
// Equalizer MAC scheduler: time-shares one MAC and one 64-entry delay line
// across all bands. Each accepted sample is written to the delay line, then
// every band sweeps all taps (one cycle per tap) followed by a one-cycle dump
// strobe of the finished accumulator.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clk_enable      : global advance qualifier (nothing changes when 0)
//   sample_valid    : new sample present
//   overrun_clr     : clears the sticky overrun flag
//   band_enable     : per-band enable, only with EQ_BAND_BYPASS_EN defined
//   dl_wr_en/addr   : delay-line write strobe and address
//   dl_rd_addr      : delay-line read address for the current tap
//   coef_addr       : coefficient ROM address {band_sel, tap_index}
//   band_sel/tap_index : current band and tap
//   mac_en/mac_clear   : MAC operate / load-instead-of-accumulate
//   band_valid      : accumulator holds the final result for band_sel
//   frame_done      : all bands finished for this sample
//   busy            : not idle
//   overrun         : sticky, sample arrived while busy
// Optional feature: define EQ_BAND_BYPASS_EN to add band_enable and skip
// disabled bands entirely.
module eq_mac_scheduler
  import eq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_enable,
  input  logic               sample_valid,
  input  logic               overrun_clr,
`ifdef EQ_BAND_BYPASS_EN
  input  logic [NUM_BANDS-1:0] band_enable,
`endif
  output logic               dl_wr_en,
  output logic [TAP_W-1:0]   dl_wr_addr,
  output logic [TAP_W-1:0]   dl_rd_addr,
  output logic [COEF_AW-1:0] coef_addr,
  output logic [BAND_W-1:0]  band_sel,
  output logic [TAP_W-1:0]   tap_index,
  output logic               mac_en,
  output logic               mac_clear,
  output logic               band_valid,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun
);

  eq_state_e            state_q;
  logic [BAND_W-1:0]    band_q;
  logic [TAP_W-1:0]     tap_q;
  logic [NUM_BANDS-1:0] en_mask_q;
  logic                 dl_wr_en_q;
  logic                 mac_en_q;
  logic                 mac_clear_q;
  logic                 band_valid_q;
  logic                 frame_done_q;
  logic                 busy_q;
  logic                 overrun_q;

  logic [NUM_BANDS-1:0] wr_mask;
  band_pick_t           first_pick;
  band_pick_t           next_pick;

`ifdef EQ_BAND_BYPASS_EN
  assign wr_mask = band_enable;
`else
  assign wr_mask = '1;
`endif

  // First band of a new frame comes from the live mask (sampled in WRITE);
  // later bands come from the mask held for the frame.
  assign first_pick = next_band(wr_mask, '0);
  assign next_pick  = next_band(en_mask_q, {1'b0, band_q} + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      band_q       <= '0;
      tap_q        <= '0;
      en_mask_q    <= '0;
      dl_wr_en_q   <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_clear_q  <= 1'b0;
      band_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (clk_enable) begin
      // Pulse outputs are registered: each is set on the transition into the
      // cycle in which it must be visible.
      dl_wr_en_q   <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_clear_q  <= 1'b0;
      band_valid_q <= 1'b0;
      frame_done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (sample_valid) begin
            state_q    <= StWrite;
            dl_wr_en_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StWrite: begin
          en_mask_q <= wr_mask;
          tap_q     <= '0;
          if (first_pick.found) begin
            state_q     <= StRun;
            band_q      <= first_pick.idx;
            mac_en_q    <= 1'b1;
            mac_clear_q <= 1'b1;
          end else begin
            // No band enabled: finish the frame straight away.
            state_q      <= StIdle;
            band_q       <= '0;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        StRun: begin
          tap_q <= tap_q + 1'b1;
          if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
            state_q      <= StDump;
            band_valid_q <= 1'b1;
            frame_done_q <= ~next_pick.found;
          end else begin
            mac_en_q <= 1'b1;
          end
        end
        StDump: begin
          if (next_pick.found) begin
            state_q     <= StRun;
            band_q      <= next_pick.idx;
            mac_en_q    <= 1'b1;
            mac_clear_q <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
      endcase

      // Set has priority over clear.
      if (sample_valid && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  eq_dl_addr_gen u_addr_gen (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (clk_enable),
    .wr_stb_i  (dl_wr_en_q),
    .tap_i     (tap_q),
    .wr_addr_o (dl_wr_addr),
    .rd_addr_o (dl_rd_addr)
  );

  assign dl_wr_en   = dl_wr_en_q;
  assign coef_addr  = {band_q, tap_q};
  assign band_sel   = band_q;
  assign tap_index  = tap_q;
  assign mac_en     = mac_en_q;
  assign mac_clear  = mac_clear_q;
  assign band_valid = band_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_eq_mac_scheduler.sv
// Scoreboard bench for eq_mac_scheduler. Stimulus pushes the expected
// write / band / frame strobes (with their enabled-cycle stamps) into a queue;
// a monitor pops and compares whenever the DUT raises one of those strobes.
module tb_eq_mac_scheduler;
  import eq_pkg::*;

  localparam int EvWr    = 0;
  localparam int EvBand  = 1;
  localparam int EvFrame = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic               clk;
  logic               rst;
  logic               clk_enable;
  logic               sample_valid;
  logic               overrun_clr;
`ifdef EQ_BAND_BYPASS_EN
  logic [NUM_BANDS-1:0] band_enable;
`endif
  logic               dl_wr_en;
  logic [TAP_W-1:0]   dl_wr_addr;
  logic [TAP_W-1:0]   dl_rd_addr;
  logic [COEF_AW-1:0] coef_addr;
  logic [BAND_W-1:0]  band_sel;
  logic [TAP_W-1:0]   tap_index;
  logic               mac_en;
  logic               mac_clear;
  logic               band_valid;
  logic               frame_done;
  logic               busy;
  logic               overrun;

  int   checks;
  int   errors;
  int   ecnt;         // enabled clock edges seen outside reset
  int   rcnt;         // raw clock edges
  logic upd;          // last edge was an enabled one
  logic toggle_mode;
  ev_t  exp_q[$];

  eq_mac_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .clk_enable   (clk_enable),
    .sample_valid (sample_valid),
    .overrun_clr  (overrun_clr),
`ifdef EQ_BAND_BYPASS_EN
    .band_enable  (band_enable),
`endif
    .dl_wr_en     (dl_wr_en),
    .dl_wr_addr   (dl_wr_addr),
    .dl_rd_addr   (dl_rd_addr),
    .coef_addr    (coef_addr),
    .band_sel     (band_sel),
    .tap_index    (tap_index),
    .mac_en       (mac_en),
    .mac_clear    (mac_clear),
    .band_valid   (band_valid),
    .frame_done   (frame_done),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clk_enable driver: steady 1, or alternating 1/0 per clock in toggle mode.
  initial begin
    clk_enable = 1'b1;
    forever begin
      @(negedge clk);
      clk_enable = toggle_mode ? ~clk_enable : 1'b1;
    end
  end

  initial begin
    ecnt = 0;
    rcnt = 0;
    upd  = 1'b0;
    forever begin
      @(posedge clk);
      rcnt++;
      upd = clk_enable && !rst;
      if (upd) ecnt++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (ecnt=%0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic sb_check(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d val=%0d at ecnt=%0d, expected nothing",
               kind, val, ecnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != ecnt) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d val=%0d ecnt=%0d, expected kind=%0d val=%0d ecnt=%0d",
                 kind, val, ecnt, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: only freshly updated strobes count, so a strobe held over a
  // disabled clock is seen once.
  initial begin
    forever begin
      @(negedge clk);
      if (upd && !rst) begin
        if (dl_wr_en)   sb_check(EvWr, int'(dl_wr_addr));
        if (band_valid) sb_check(EvBand, int'(band_sel));
        if (frame_done) sb_check(EvFrame, 0);
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({dl_wr_en, dl_wr_addr, dl_rd_addr, coef_addr, band_sel, tap_index,
                mac_en, mac_clear, band_valid, frame_done, busy, overrun});
  endfunction

  task automatic wait_ecnt(input int target);
    int n;
    n = 0;
    while (ecnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ecnt", ecnt, target);
  endtask

  // Issue one sample; returns the enabled-edge count of the accepting edge and
  // queues every strobe the frame must produce.
  task automatic send_sample(input logic [7:0] mask, input int wr_addr, output int a);
    int k;
    ev_t e;
    sample_valid = 1'b1;
    do @(posedge clk); while (!clk_enable);
    #1;
    a = ecnt;
    sample_valid = 1'b0;
    e.kind = EvWr; e.val = wr_addr; e.cyc = a;
    exp_q.push_back(e);
    k = 0;
    for (int b = 0; b < int'(NUM_BANDS); b++) begin
      if (mask[b]) begin
        k++;
        e.kind = EvBand; e.val = b; e.cyc = a + k * 65;
        exp_q.push_back(e);
      end
    end
    e.kind = EvFrame; e.val = 0; e.cyc = (k == 0) ? a + 1 : a + k * 65;
    exp_q.push_back(e);
  endtask

  initial begin
    int a;
    int r0;
    int n;
    checks       = 0;
    errors       = 0;
    toggle_mode  = 1'b0;
    sample_valid = 1'b0;
    overrun_clr  = 1'b0;
`ifdef EQ_BAND_BYPASS_EN
    band_enable  = 8'hFF;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 0);

    // Single frame, all bands.
    send_sample(8'hFF, 0, a);
    chk("write_busy", busy, 1);
    wait_ecnt(a + 1);
    chk("tap0_mac_en", mac_en, 1);
    chk("tap0_mac_clear", mac_clear, 1);
    chk("tap0_rd_addr", dl_rd_addr, 0);
    wait_ecnt(a + 2);
    chk("tap1_mac_clear", mac_clear, 0);
    chk("tap1_rd_addr", dl_rd_addr, 63);
    chk("tap1_coef", coef_addr, 1);
    wait_ecnt(a + 65);
    chk("dump_mac_en", mac_en, 0);
    wait_ecnt(a + 67);
    chk("band1_tap1_coef", coef_addr, 65);
    wait_ecnt(a + 520);
    chk("last_dump_frame_done", frame_done, 1);
    chk("last_dump_busy", busy, 1);
    wait_ecnt(a + 521);
    chk("idle_busy", busy, 0);
    chk("idle_frame_done", frame_done, 0);

    // Overrun behaviour while a frame is running.
    send_sample(8'hFF, 1, a);
    wait_ecnt(a + 99);
    sample_valid = 1'b1;
    wait_ecnt(a + 100);
    sample_valid = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_ecnt(a + 199);
    sample_valid = 1'b1;
    overrun_clr  = 1'b1;
    wait_ecnt(a + 200);
    sample_valid = 1'b0;
    chk("overrun_set_wins", overrun, 1);
    wait_ecnt(a + 201);
    overrun_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);
    wait_ecnt(a + 519);
    sample_valid = 1'b1;
    wait_ecnt(a + 520);
    sample_valid = 1'b0;
    chk("overrun_last_dump", overrun, 1);
    wait_ecnt(a + 522);
    chk("dropped_sample_idle", busy, 0);
    overrun_clr = 1'b1;
    wait_ecnt(a + 523);
    overrun_clr = 1'b0;
    chk("overrun_cleared2", overrun, 0);

    // clk_enable alternating every clock.
    toggle_mode = 1'b1;
    @(negedge clk);
    send_sample(8'hFF, 2, a);
    r0 = rcnt;
    n = 0;
    while (!frame_done && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("toggle_frame_clocks", rcnt - r0, 1040);
    @(negedge clk);
    chk("toggle_frame_hold", frame_done, 1);
    @(negedge clk);
    chk("toggle_busy_low", busy, 0);
    chk("toggle_idle_clocks", rcnt - r0, 1042);
    toggle_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a frame.
    send_sample(8'hFF, 3, a);
    wait_ecnt(a + 299);
    #1 rst = 1'b1;
    #1 chk("async_reset_outputs", all_outs(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("held_reset_outputs", all_outs(), 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // 65 frames: write pointer wraps 63 -> 0.
    for (int i = 0; i < 65; i++) begin
      send_sample(8'hFF, i % 64, a);
      wait_ecnt(a + 1);
      chk("wrap_tap0_rd", dl_rd_addr, i % 64);
      wait_ecnt(a + 2);
      chk("wrap_tap1_rd", dl_rd_addr, (i + 63) % 64);
      wait_ecnt(a + 529);
    end

`ifdef EQ_BAND_BYPASS_EN
    band_enable = 8'h81;
    send_sample(8'h81, 1, a);
    wait_ecnt(a + 1);
    band_enable = 8'hFF;  // must not affect the frame already under way
    wait_ecnt(a + 66);
    chk("bypass_jump_band", band_sel, 7);
    wait_ecnt(a + 131);
    chk("bypass_idle", busy, 0);
    band_enable = 8'h00;
    send_sample(8'h00, 2, a);
    wait_ecnt(a + 1);
    chk("bypass_none_done", frame_done, 1);
    chk("bypass_none_busy", busy, 0);
    wait_ecnt(a + 3);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d",
             checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
